// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared data-memory constants: address width and RISC-V func3 access codes
package dmem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int MEM_SIZE   = 1 << ADDR_W_DEF;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_FETCH,
    GNT_DATA
  } grant_e;

endpackage

// File: rtl/dmem_port_arbiter_check.sv
// rtl/dmem_port_arbiter_check.sv - dmem_access_check: flags illegal func3 or misaligned load/store
module dmem_access_check
  import dmem_port_arbiter_pkg::*;
(
  input  logic       we,
  input  logic [2:0] func3,
  input  logic [1:0] addr_lo,
  output logic       illegal
);

  logic bad_func3;
  logic misaligned;

  always_comb begin
    bad_func3 = 1'b1;
    case (func3)
      F3_LB, F3_LH, F3_LW: bad_func3 = 1'b0;
      F3_LBU, F3_LHU:      bad_func3 = we;
      default:             bad_func3 = 1'b1;
    endcase
  end

  assign misaligned = ((func3[1:0] == 2'b01) && addr_lo[0]) ||
                      ((func3[1:0] == 2'b10) && (addr_lo != 2'b00));

  assign illegal = bad_func3 | misaligned;

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data memory between fetch and load/store, data first with fetch anti-starvation
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             if_elig;
  logic             d_elig;
  logic             d_illegal;
  logic             if_misaligned;
  grant_e           gnt;

  dmem_access_check u_check (
    .we      (d_we),
    .func3   (d_func3),
    .addr_lo (d_addr[1:0]),
    .illegal (d_illegal)
  );

  // The ack cycle is masked so a request still held high is not served twice.
  assign if_elig       = if_req & ~if_ack;
  assign d_elig        = d_req & ~d_ack;
  assign if_misaligned = (if_addr[1:0] != 2'b00);

  always_comb begin
    gnt = GNT_NONE;
    if (if_elig && d_elig)
      gnt = (starve_cnt == STARVE_MAX) ? GNT_FETCH : GNT_DATA;
    else if (if_elig)
      gnt = GNT_FETCH;
    else if (d_elig)
      gnt = GNT_DATA;
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_func3 = 3'b000;
    case (gnt)
      GNT_FETCH: begin
        mem_read  = ~if_misaligned;
        mem_addr  = if_addr;
        mem_func3 = F3_LW;
      end
      GNT_DATA: begin
        mem_read  = ~d_illegal & ~d_we;
        mem_write = ~d_illegal & d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_func3 = d_func3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_ack     <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
      starve_cnt <= '0;
    end else begin
      if_ack <= (gnt == GNT_FETCH);
      if_err <= (gnt == GNT_FETCH) && if_misaligned;
      d_ack  <= (gnt == GNT_DATA);
      d_err  <= (gnt == GNT_DATA) && d_illegal;
      if (gnt == GNT_FETCH)
        if_rdata <= if_misaligned ? 32'h0 : mem_rdata;
      if (gnt == GNT_DATA) begin
        if (d_illegal)
          d_rdata <= 32'h0;
        else if (!d_we)
          d_rdata <= mem_rdata;
      end
      if (gnt == GNT_FETCH || !if_req)
        starve_cnt <= '0;
      else if (if_elig && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - randomized and directed bench against a behavioural arbiter and memory model
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int AW    = 12;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack, if_err;
  logic [31:0]   if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [2:0]    d_func3 = 3'b0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic          d_ack, d_err;
  logic [31:0]   d_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [2:0]    mem_func3;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  logic [7:0] mem [0:4095];

  function automatic logic [31:0] mem_load(input logic [11:0] a, input logic [2:0] f3);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a];
    b1 = mem[a + 12'd1];
    b2 = mem[a + 12'd2];
    b3 = mem[a + 12'd3];
    case (f3)
      3'd0:    return {{24{b0[7]}}, b0};
      3'd1:    return {{16{b1[7]}}, b1, b0};
      3'd4:    return {24'h0, b0};
      3'd5:    return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always_comb mem_rdata = mem_load(mem_addr, mem_func3);

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (mem_func3[1:0] != 2'b00) mem[mem_addr + 12'd1] <= mem_wdata[15:8];
      if (mem_func3[1:0] == 2'b10) begin
        mem[mem_addr + 12'd2] <= mem_wdata[23:16];
        mem[mem_addr + 12'd3] <= mem_wdata[31:24];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state: what the registered outputs should show in the current cycle.
  bit          m_if_ack, m_if_err, m_d_ack, m_d_err, m_if_known;
  logic [31:0] m_if_rdata, m_d_rdata;
  int          m_starve;

  task automatic model_reset();
    m_if_ack = 0; m_if_err = 0; m_d_ack = 0; m_d_err = 0; m_if_known = 1;
    m_if_rdata = 0; m_d_rdata = 0; m_starve = 0;
  endtask

  function automatic bit ref_illegal(input bit we, input int f3, input int addr);
    bit legal;
    int size;
    legal = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    size = 1 << (f3 % 4);
    return !legal || (addr % size != 0);
  endfunction

  // Called at posedge+1 with inputs set; checks this cycle and advances to the next posedge+1.
  task automatic step();
    bit ife, de, fg, dg, dill, fmis;
    logic [31:0] rd_f, rd_d;
    #1;
    ife  = if_req && !m_if_ack;
    de   = d_req && !m_d_ack;
    fg   = (ife && de) ? (m_starve == LIMIT) : ife;
    dg   = de && !fg;
    dill = ref_illegal(d_we, int'(d_func3), int'(d_addr));
    fmis = (int'(if_addr) % 4) != 0;
    chk("mem_read",  mem_read,  (fg && !fmis) || (dg && !dill && !d_we));
    chk("mem_write", mem_write, dg && !dill && d_we);
    if (fg && !fmis) begin
      chk("mem_addr_f",  mem_addr,  if_addr);
      chk("mem_func3_f", mem_func3, 3'b010);
    end else if (dg && !dill) begin
      chk("mem_addr_d",  mem_addr,  d_addr);
      chk("mem_func3_d", mem_func3, d_func3);
      chk("mem_wdata_d", mem_wdata, d_wdata);
    end else if (!fg && !dg) begin
      chk("mem_addr_idle",  mem_addr,  0);
      chk("mem_func3_idle", mem_func3, 0);
      chk("mem_wdata_idle", mem_wdata, 0);
    end
    chk("if_ack", if_ack, m_if_ack);
    chk("if_err", if_err, m_if_err);
    if (m_if_known) chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_ack",   d_ack,   m_d_ack);
    chk("d_err",   d_err,   m_d_err);
    chk("d_rdata", d_rdata, m_d_rdata);
    rd_f = mem_load(if_addr, 3'b010);
    rd_d = mem_load(d_addr, d_func3);
    @(posedge clk);
    #1;
    m_if_ack = fg;
    m_if_err = fg && fmis;
    if (fg) begin
      m_if_known = !fmis;
      if (!fmis) m_if_rdata = rd_f;
    end
    m_d_ack = dg;
    m_d_err = dg && dill;
    if (dg) begin
      if (dill) m_d_rdata = 0;
      else if (!d_we) m_d_rdata = rd_d;
    end
    if (fg || !if_req) m_starve = 0;
    else if (ife && m_starve < LIMIT) m_starve++;
  endtask

  task automatic data_op(input bit we, input logic [2:0] f3, input logic [11:0] a,
                         input logic [31:0] wd);
    int n;
    d_req = 1; d_we = we; d_func3 = f3; d_addr = a; d_wdata = wd;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_d_ack && n < 8);
    if (!m_d_ack) chk("d_ack_timeout", 0, 1);
    d_req = 0;
  endtask

  function automatic logic [2:0] rand_f3(input bit we);
    logic [2:0] tbl [5];
    tbl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if ($urandom_range(0, 9) == 0) return 3'($urandom_range(0, 7));
    return we ? tbl[$urandom_range(0, 2)] : tbl[$urandom_range(0, 4)];
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h010] = 8'h78; mem[12'h011] = 8'h56; mem[12'h012] = 8'h34; mem[12'h013] = 8'h12;
    for (int i = 12'h40; i < 12'h44; i++) mem[i] = 8'(8'hA0 + i);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_read", mem_read, 0);
    rst = 1;

    data_op(0, F3_LW, 12'h010, 0);
    chk("lw_0x10", d_rdata, 32'h12345678);
    data_op(1, F3_SH, 12'h020, 32'h0000BEEF);
    data_op(0, F3_LH, 12'h020, 0);
    chk("lh_0x20", d_rdata, 32'hFFFFBEEF);
    data_op(0, F3_LHU, 12'h020, 0);
    chk("lhu_0x20", d_rdata, 32'h0000BEEF);
    data_op(0, F3_LW, 12'h022, 0);
    chk("lw_mis_err", d_err, 1);
    chk("lw_mis_rdata", d_rdata, 0);
    data_op(1, 3'b011, 12'h030, 32'hDEADBEEF);
    chk("sw_f3_3_err", d_err, 1);
    chk("sw_f3_3_mem", {mem[12'h033], mem[12'h032], mem[12'h031], mem[12'h030]}, 0);

    // Fetch held high through its ack: the ack cycle must not grant again.
    if_req = 1; if_addr = 12'h040;
    step();
    chk("fetch_ack", if_ack, 1);
    chk("fetch_rdata", if_rdata, 32'hE3E2E1E0);
    step();
    chk("fetch_no_dup", if_ack, 0);
    if_req = 0;
    step();

    // Both ports busy: fetch held, data issues a new load on every ack.
    if_req = 1; if_addr = 12'h044;
    d_req = 1; d_we = 0; d_func3 = F3_LW; d_addr = 12'h010;
    for (int c = 0; c < 10; c++) begin
      if (m_if_ack) if_addr = 12'(4 * $urandom_range(16, 20));
      if (m_d_ack) d_addr = 12'(4 * $urandom_range(0, 8));
      step();
    end
    if_req = 0; d_req = 0;
    step();

    for (int c = 0; c < 3000; c++) begin
      if (!if_req || m_if_ack) begin
        if_req = $urandom_range(0, 1);
        if_addr = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 63))
                                              : 12'(4 * $urandom_range(0, 15));
      end
      if (!d_req || m_d_ack) begin
        d_req = $urandom_range(0, 1);
        d_we = $urandom_range(0, 1);
        d_func3 = rand_f3(d_we);
        d_addr = 12'($urandom_range(0, 63));
        d_wdata = $urandom;
      end
      step();
    end
    if_req = 0; d_req = 0;
    step();

    // Reset while a granted load is in its request cycle.
    d_req = 1; d_we = 0; d_func3 = F3_LW; d_addr = 12'h010;
    #1;
    chk("rst_mid_grant", mem_read, 1);
    rst = 0;
    #1;
    chk("rst_mid_d_ack", d_ack, 0);
    chk("rst_mid_d_rdata", d_rdata, 0);
    chk("rst_mid_if_rdata", if_rdata, 0);
    chk("rst_mid_d_err", d_err, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_held_d_ack", d_ack, 0);
    d_req = 0;
    rst = 1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
